// File: rtl/root_uplink_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module : root_uplink_collector_pkg
// Brief  : Uplink message encoding and collector state codes shared with leaves.
// Rev    : 1.0
// ============================================================================
package root_uplink_collector_pkg;

    localparam int c_MSG_W    = 64;
    localparam int c_TYPE_LSB = 56;
    localparam int c_TYPE_W   = 8;
    localparam int c_SRC_LSB  = 48;
    localparam int c_SRC_W    = 8;
    localparam int c_PAY_W    = 48;
    localparam int c_TID_LSB  = 0;
    localparam int c_TID_W    = 16;

    localparam logic [c_TYPE_W-1:0] c_TYPE_RESULT = 8'h01;
    localparam logic [c_TYPE_W-1:0] c_TYPE_DONE   = 8'h02;

    localparam int c_ERR_W        = 5;
    localparam int c_ERR_BAD_TYPE = 0;
    localparam int c_ERR_SRC      = 1;
    localparam int c_ERR_DUP_DONE = 2;
    localparam int c_ERR_TID      = 3;
    localparam int c_ERR_TIMEOUT  = 4;

    localparam int               c_ST_W       = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_COLLECT = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_REPORT  = 2'd2;

    // Packed layout mirrors the field positions above, MSB first.
    typedef struct packed {
        logic [c_TYPE_W-1:0] mtype;
        logic [c_SRC_W-1:0]  src;
        logic [c_PAY_W-1:0]  payload;
    } msg_t;

endpackage
`default_nettype wire

// File: rtl/root_uplink_collector_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin one-hot grant; priority moves past the accepted requester.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_found;

    always_comb begin : p_pick
        o_grant     = '0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                w_grant_idx     = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_grant_idx == IDX_W'(N - 1)) ? '0 : w_grant_idx + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/root_uplink_collector.sv
`default_nettype none
// ============================================================================
// Module : root_uplink_collector
// Brief  : Arbitrates leaf uplinks, forwards RESULTs, tracks DONE rounds.
// Rev    : 1.0
// ============================================================================
module root_uplink_collector
    import root_uplink_collector_pkg::*;
#(
    parameter int NUM_LEAVES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [64*NUM_LEAVES-1:0]  up_rx_data,
    input  logic [NUM_LEAVES-1:0]     up_rx_valid,
    output logic [NUM_LEAVES-1:0]     up_rx_ready,
    output logic [63:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      round_done,
    output logic [15:0]               round_id,
    output logic [4:0]                err_flags
);

    localparam int                    TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NUM_LEAVES-1:0] c_ALL_DONE = '1;

    logic [c_ST_W-1:0]     r_state, w_state_nxt;
    logic [NUM_LEAVES-1:0] r_done_mask, w_done_mask_nxt;
    logic [c_TID_W-1:0]    r_latched_id, w_latched_id_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [c_MSG_W-1:0]    r_out_data;
    logic                  r_out_valid;
    logic                  r_round_done;
    logic [c_TID_W-1:0]    r_round_id;
    logic [c_ERR_W-1:0]    r_err_flags;

    logic [NUM_LEAVES-1:0] w_eligible, w_grant;
    logic [c_TYPE_W-1:0]   w_leaf_type;
    logic [c_SRC_W-1:0]    w_leaf_src, w_exp_src;
    msg_t                  w_msg;
    logic                  w_accept, w_space;
    logic                  w_result_take, w_done_take;
    logic                  w_timeout, w_report_enter;
    logic [c_ERR_W-1:0]    w_err_set;

    assign w_space = !r_out_valid || out_ready;

    // Blocked leaves stay out of arbitration so they cannot stall the others.
    always_comb begin : p_eligible
        w_eligible  = '0;
        w_leaf_type = '0;
        w_leaf_src  = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            w_leaf_type   = up_rx_data[i*c_MSG_W + c_TYPE_LSB +: c_TYPE_W];
            w_leaf_src    = up_rx_data[i*c_MSG_W + c_SRC_LSB +: c_SRC_W];
            w_eligible[i] = up_rx_valid[i]
                && !(w_leaf_type == c_TYPE_RESULT && w_leaf_src == c_SRC_W'(i + 1) && !w_space)
                && !(w_leaf_type == c_TYPE_DONE && r_state == c_ST_REPORT);
        end
    end

    rr_arbiter #(
        .N (NUM_LEAVES)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (reset),
        .i_req     (w_eligible),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign w_accept    = |w_grant;
    assign up_rx_ready = reset ? '0 : w_grant;

    always_comb begin : p_select
        w_msg     = '0;
        w_exp_src = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (w_grant[i]) begin
                w_msg     = msg_t'(up_rx_data[i*c_MSG_W +: c_MSG_W]);
                w_exp_src = c_SRC_W'(i + 1);
            end
        end
    end

    always_comb begin : p_classify
        w_err_set     = '0;
        w_result_take = 1'b0;
        w_done_take   = 1'b0;
        if (w_accept) begin
            if (w_msg.mtype != c_TYPE_RESULT && w_msg.mtype != c_TYPE_DONE) begin
                w_err_set[c_ERR_BAD_TYPE] = 1'b1;
            end else if (w_msg.src != w_exp_src) begin
                w_err_set[c_ERR_SRC] = 1'b1;
            end else if (w_msg.mtype == c_TYPE_RESULT) begin
                w_result_take = 1'b1;
            end else if ((r_done_mask & w_grant) != '0) begin
                w_err_set[c_ERR_DUP_DONE] = 1'b1;
            end else if (r_state == c_ST_COLLECT
                         && w_msg.payload[c_TID_LSB +: c_TID_W] != r_latched_id) begin
                w_err_set[c_ERR_TID] = 1'b1;
            end else begin
                w_done_take = 1'b1;
            end
        end
    end

    always_comb begin : p_fsm_next
        w_state_nxt      = r_state;
        w_done_mask_nxt  = r_done_mask;
        w_latched_id_nxt = r_latched_id;
        w_timeout        = 1'b0;
        w_report_enter   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_done_take) begin
                    w_done_mask_nxt  = r_done_mask | w_grant;
                    w_latched_id_nxt = w_msg.payload[c_TID_LSB +: c_TID_W];
                    w_state_nxt      = c_ST_COLLECT;
                end
            end
            c_ST_COLLECT: begin
                if (r_done_mask == c_ALL_DONE) begin
                    w_state_nxt     = c_ST_REPORT;
                    w_done_mask_nxt = '0;
                    w_report_enter  = 1'b1;
                end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt     = c_ST_IDLE;
                    w_done_mask_nxt = '0;
                    w_timeout       = 1'b1;
                end else if (w_done_take) begin
                    w_done_mask_nxt = r_done_mask | w_grant;
                end
            end
            c_ST_REPORT: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt     = c_ST_IDLE;
                w_done_mask_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_done_mask  <= '0;
            r_latched_id <= '0;
            r_timer      <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_round_done <= 1'b0;
            r_round_id   <= '0;
            r_err_flags  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_mask  <= w_done_mask_nxt;
            r_latched_id <= w_latched_id_nxt;
            r_timer      <= (r_state == c_ST_COLLECT) ? r_timer + TMR_W'(1) : '0;
            r_round_done <= w_report_enter;
            if (w_report_enter) begin
                r_round_id <= r_latched_id;
            end
            if (w_result_take) begin
                r_out_data  <= w_msg;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_err_flags <= r_err_flags | w_err_set | {w_timeout, {(c_ERR_W-1){1'b0}}};
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign round_done = r_round_done;
    assign round_id   = r_round_id;
    assign err_flags  = r_err_flags;

endmodule
`default_nettype wire

// File: tb/tb_root_uplink_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_root_uplink_collector
// Brief  : Self-checking bench for root_uplink_collector (4 leaves, timeout 16).
// Rev    : 1.0
// ============================================================================
module tb_root_uplink_collector;

    localparam int NL = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [63:0]     leaf_msg [NL];
    logic [NL-1:0]   vld = '0;
    logic [64*NL-1:0] up_rx_data;
    logic [NL-1:0]   up_rx_ready;
    logic [63:0]     out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            round_done;
    logic [15:0]     round_id;
    logic [4:0]      err_flags;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        up_rx_data = '0;
        for (int i = 0; i < NL; i++) up_rx_data[i*64 +: 64] = leaf_msg[i];
    end

    root_uplink_collector #(
        .NUM_LEAVES     (NL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .up_rx_data  (up_rx_data),
        .up_rx_valid (vld),
        .up_rx_ready (up_rx_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .round_done  (round_done),
        .round_id    (round_id),
        .err_flags   (err_flags)
    );

    function automatic logic [63:0] mk(input logic [7:0] t, input logic [7:0] s, input logic [47:0] p);
        return {t, s, p};
    endfunction

    function automatic logic [63:0] done_msg(input int leaf, input logic [15:0] id);
        return mk(8'h02, 8'(leaf + 1), {32'h0, id});
    endfunction

    function automatic logic [63:0] res_msg(input int leaf);
        return mk(8'h01, 8'(leaf + 1), {16'($urandom), 32'($urandom)});
    endfunction

    // Round-robin rule: first requester at or after the priority pointer.
    function automatic int rr_pick(input int ptr, input logic [NL-1:0] req);
        for (int k = 0; k < NL; k++) if (req[(ptr + k) % NL]) return (ptr + k) % NL;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; vld = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic send_one(input int leaf, input logic [63:0] msg);
        bit got;
        got = 1'b0;
        leaf_msg[leaf] = msg; vld[leaf] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            #2;
            if (up_rx_ready[leaf]) got = 1'b1;
            step();
        end
        vld[leaf] = 1'b0;
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL handshake leaf%0d: ready=0 want 1 within 20 cycles", leaf); end
    endtask

    // Call right after the last DONE of a round was accepted.
    task automatic check_round(input logic [15:0] id);
        #2;
        n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("FAIL round_done_early: got %b want 0", round_done); end
        step(); #2;
        n_cmp++; if (round_done !== 1'b1) begin n_bad++; $display("FAIL round_done_pulse: got %b want 1", round_done); end
        n_cmp++; if (round_id !== id) begin n_bad++; $display("FAIL round_id: got %h want %h", round_id, id); end
        step(); #2;
        n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("FAIL round_done_width: got %b want 0", round_done); end
    endtask

    task automatic full_round(input logic [15:0] id);
        for (int i = 0; i < NL; i++) send_one(i, done_msg(i, id));
        check_round(id);
    endtask

    task automatic test_reset();
        for (int i = 0; i < NL; i++) leaf_msg[i] = res_msg(i);
        vld = '1; out_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        n_cmp++; if (up_rx_ready !== '0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", up_rx_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("FAIL rst_round_done: got %b want 0", round_done); end
        n_cmp++; if (round_id !== '0) begin n_bad++; $display("FAIL rst_round_id: got %h want 0", round_id); end
        n_cmp++; if (err_flags !== '0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_flags); end
        step(); step(); #2;
        n_cmp++; if (up_rx_ready !== '0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_held: ready=%b out_valid=%b want 0/0", up_rx_ready, out_valid);
        end
        vld = '0; reset = 1'b0;
        step();
    endtask

    task automatic test_result_order();
        logic [63:0] r [NL];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin r[i] = res_msg(i); leaf_msg[i] = r[i]; end
        vld = '1;
        for (int c = 0; c < NL; c++) begin
            #2;
            n_cmp++; if (up_rx_ready !== NL'(1 << c)) begin n_bad++; $display("FAIL order_grant%0d: got %b want %b", c, up_rx_ready, NL'(1 << c)); end
            n_cmp++; if (out_valid !== (c > 0)) begin n_bad++; $display("FAIL order_valid%0d: got %b want %b", c, out_valid, c > 0); end
            if (c > 0) begin
                n_cmp++; if (out_data !== r[c-1]) begin n_bad++; $display("FAIL order_data%0d: got %h want %h", c, out_data, r[c-1]); end
            end
            step();
            vld[c] = 1'b0;
        end
        #2;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== r[NL-1]) begin
            n_bad++; $display("FAIL order_last: valid=%b data=%h want 1/%h", out_valid, out_data, r[NL-1]);
        end
        step(); #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL order_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b;
        do_reset();
        a = res_msg(0); b = res_msg(1);
        send_one(0, a);
        leaf_msg[1] = b; vld[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            n_cmp++; if (up_rx_ready !== '0) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0", c, up_rx_ready); end
            n_cmp++; if (out_data !== a || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold%0d: data=%h valid=%b want %h/1", c, out_data, out_valid, a);
            end
            step();
        end
        out_ready = 1'b1;
        #2;
        n_cmp++; if (up_rx_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_drain_ready: got %b want 0010", up_rx_ready); end
        step();
        vld[1] = 1'b0;
        #2;
        n_cmp++; if (out_data !== b || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_next: data=%h valid=%b want %h/1", out_data, out_valid, b);
        end
        step();
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 1'b1;
        send_one(1, done_msg(1, 16'h0007));
        send_one(1, done_msg(1, 16'h0007));
        n_cmp++; if (err_flags !== 5'b00100) begin n_bad++; $display("FAIL err_dup: got %b want 00100", err_flags); end
        send_one(2, done_msg(2, 16'h0008));
        n_cmp++; if (err_flags !== 5'b01100) begin n_bad++; $display("FAIL err_tid: got %b want 01100", err_flags); end
        send_one(0, mk(8'h55, 8'd1, 48'h123));
        n_cmp++; if (err_flags !== 5'b01101) begin n_bad++; $display("FAIL err_type: got %b want 01101", err_flags); end
        send_one(3, mk(8'h01, 8'd1, 48'h456));
        #2;
        n_cmp++; if (err_flags !== 5'b01111) begin n_bad++; $display("FAIL err_src: got %b want 01111", err_flags); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL err_dropped: got %b want 0", out_valid); end
        send_one(0, done_msg(0, 16'h0007));
        send_one(2, done_msg(2, 16'h0007));
        send_one(3, done_msg(3, 16'h0007));
        check_round(16'h0007);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) send_one(i, done_msg(i, 16'h0009));
        for (int c = 0; c < TO - 3; c++) begin
            step(); #2;
            n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("FAIL to_no_round%0d: got %b want 0", c, round_done); end
        end
        n_cmp++; if (err_flags !== 5'b00000) begin n_bad++; $display("FAIL to_early: got %b want 00000", err_flags); end
        step(); #2;
        n_cmp++; if (err_flags !== 5'b10000) begin n_bad++; $display("FAIL to_flag: got %b want 10000", err_flags); end
        n_cmp++; if (round_done !== 1'b0) begin n_bad++; $display("FAIL to_round_done: got %b want 0", round_done); end
        full_round(16'h000A);
        n_cmp++; if (err_flags !== 5'b10000) begin n_bad++; $display("FAIL to_sticky: got %b want 10000", err_flags); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] x, y;
        do_reset();
        out_ready = 1'b1;
        x = res_msg(0); y = res_msg(1);
        for (int i = 0; i < 3; i++) send_one(i, done_msg(i, 16'h0033));
        leaf_msg[3] = done_msg(3, 16'h0033); vld[3] = 1'b1;
        #2;
        n_cmp++; if (up_rx_ready !== 4'b1000) begin n_bad++; $display("FAIL b2b_done: got %b want 1000", up_rx_ready); end
        step();
        vld[3] = 1'b0; leaf_msg[0] = x; vld[0] = 1'b1;
        #2;
        n_cmp++; if (up_rx_ready !== 4'b0001) begin n_bad++; $display("FAIL b2b_res0: got %b want 0001", up_rx_ready); end
        step();
        vld[0] = 1'b0; leaf_msg[1] = y; vld[1] = 1'b1;
        #2;
        n_cmp++; if (round_done !== 1'b1 || round_id !== 16'h0033) begin
            n_bad++; $display("FAIL b2b_round: done=%b id=%h want 1/0033", round_done, round_id);
        end
        n_cmp++; if (up_rx_ready !== 4'b0010) begin n_bad++; $display("FAIL b2b_res1: got %b want 0010", up_rx_ready); end
        n_cmp++; if (out_data !== x || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_x: got %h want %h", out_data, x); end
        step();
        vld[1] = 1'b0;
        #2;
        n_cmp++; if (out_data !== y || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_y: got %h want %h", out_data, y); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        full_round(16'h0077);
        send_one(0, mk(8'hEE, 8'd1, 48'h0));
        out_ready = 1'b0;
        send_one(1, done_msg(1, 16'h0004));
        send_one(2, done_msg(2, 16'h0004));
        send_one(3, res_msg(3));
        leaf_msg[0] = done_msg(0, 16'h0004); vld[0] = 1'b1;
        reset = 1'b1;
        #2;
        n_cmp++; if (up_rx_ready !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            n_bad++; $display("FAIL mid_rst_out: ready=%b valid=%b data=%h want 0", up_rx_ready, out_valid, out_data);
        end
        n_cmp++; if (round_id !== '0 || round_done !== 1'b0 || err_flags !== '0) begin
            n_bad++; $display("FAIL mid_rst_status: id=%h done=%b err=%b want 0", round_id, round_done, err_flags);
        end
        vld = '0;
        step();
        reset = 1'b0; out_ready = 1'b1;
        step();
        full_round(16'h0005);
        n_cmp++; if (out_valid !== 1'b0 || err_flags !== '0) begin
            n_bad++; $display("FAIL mid_after: valid=%b err=%b want 0/0", out_valid, err_flags);
        end
    endtask

    task automatic test_random_results();
        logic [63:0]   m_od;
        bit            m_ov;
        int            m_ptr, g;
        logic [NL-1:0] exp_rdy;
        do_reset();
        m_od = '0; m_ov = 1'b0; m_ptr = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NL; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin leaf_msg[i] = res_msg(i); vld[i] = 1'b1; end
            end
            g = (!m_ov || out_ready) ? rr_pick(m_ptr, vld) : -1;
            exp_rdy = (g >= 0) ? NL'(1 << g) : '0;
            #2;
            n_cmp++; if (up_rx_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, up_rx_ready, exp_rdy); end
            n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, m_ov); end
            if (m_ov) begin
                n_cmp++; if (out_data !== m_od) begin n_bad++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, out_data, m_od); end
            end
            step();
            if (g >= 0) begin
                m_od = leaf_msg[g]; m_ov = 1'b1; m_ptr = (g + 1) % NL; vld[g] = 1'b0;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
        vld = '0; out_ready = 1'b1;
        step();
        n_cmp++; if (err_flags !== '0) begin n_bad++; $display("FAIL rnd_err: got %b want 0", err_flags); end
    endtask

    task automatic test_random_rounds();
        int          ord [NL];
        int          j, t;
        logic [15:0] id;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            id = 16'($urandom);
            for (int i = 0; i < NL; i++) ord[i] = i;
            for (int i = NL - 1; i > 0; i--) begin
                j = $urandom_range(0, i); t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int k = 0; k < NL; k++) begin
                repeat ($urandom_range(0, 2)) step();
                send_one(ord[k], done_msg(ord[k], id));
            end
            check_round(id);
        end
        n_cmp++; if (err_flags !== '0) begin n_bad++; $display("FAIL rr_err: got %b want 0", err_flags); end
    endtask

    initial begin
        for (int i = 0; i < NL; i++) leaf_msg[i] = '0;
        test_reset();
        test_result_order();
        test_backpressure();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random_results();
        test_random_rounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
